// File: rtl/ram_bit_stream_reader.sv
// Serial bit-stream reader for a 1-bit block RAM read port.
// Absorbs the one-cycle read latency and delivers a valid/ready stream through a 2-entry buffer.
module ram_bit_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned LEN_WIDTH  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_do,
    output logic                  data_out,
    output logic                  data_valid,
    input  logic                  data_ready
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [LEN_WIDTH-1:0]  rd_left;
    logic [LEN_WIDTH-1:0]  out_left;
    logic [1:0]            buf_q;
    logic [1:0]            cnt;
    logic                  in_flight;

    logic                  pop;
    logic [1:0]            cnt_nxt;
    logic [LEN_WIDTH-1:0]  out_left_nxt;
    logic                  room;

    // The bit returning on ram_do is the logical tail of the buffer; it heads the stream when nothing is buffered.
    assign data_valid   = (cnt != 2'd0) || in_flight;
    assign data_out     = (cnt != 2'd0) ? buf_q[0] : (in_flight & ram_do);
    assign pop          = data_valid && data_ready;
    assign cnt_nxt      = cnt + 2'(in_flight) - 2'(pop);
    assign out_left_nxt = pop ? out_left - LEN_WIDTH'(1) : out_left;
    // A read issued now lands after the one presented this cycle; both must fit in the buffer.
    assign room         = (3'(cnt_nxt) + 3'(ram_en)) < 3'd2;

    // Output buffer: captures every returned bit, shifts on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= 2'b00;
            cnt       <= 2'd0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= ram_en;
            cnt       <= cnt_nxt;
            if (pop) begin
                if (cnt == 2'd2) begin
                    buf_q[0] <= buf_q[1];
                    if (in_flight) buf_q[1] <= ram_do;
                end else if (cnt == 2'd1 && in_flight) begin
                    buf_q[0] <= ram_do;
                end
            end else if (in_flight) begin
                if (cnt == 2'd0) buf_q[0] <= ram_do;
                else             buf_q[1] <= ram_do;
            end
        end
    end

    // Sequencer: read issue, length tracking and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_addr  <= '0;
            rd_left  <= '0;
            out_left <= '0;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            ram_en   <= 1'b0;
            done     <= 1'b0;
            out_left <= out_left_nxt;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start && !done) begin
                        out_left <= length;
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            ram_en   <= 1'b1;
                            ram_addr <= start_addr;
                            rd_addr  <= start_addr + ADDR_WIDTH'(1);
                            rd_left  <= length - LEN_WIDTH'(1);
                        end
                    end
                end
                RUN: begin
                    if (rd_left == '0) begin
                        state <= FLUSH;
                    end else if (room) begin
                        ram_en   <= 1'b1;
                        ram_addr <= rd_addr;
                        rd_addr  <= rd_addr + ADDR_WIDTH'(1);
                        rd_left  <= rd_left - LEN_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    if (out_left_nxt == '0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bit_stream_reader.sv
// Directed bench for ram_bit_stream_reader with a behavioural 1-bit RAM (bit k = k[0]^k[3]).
module tb_ram_bit_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] start_addr;
    logic [14:0] length;
    logic        busy, done, ram_en, ram_do, data_out, data_valid, data_ready;
    logic [13:0] ram_addr;

    always #5 clk = ~clk;

    ram_bit_stream_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_do(ram_do),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready)
    );

    logic mem [0:16383];
    always @(posedge clk) if (ram_en) ram_do <= mem[ram_addr];

    int total = 0;
    int bad   = 0;

    logic bits_q[$];
    int   addr_q[$];
    int   n_en, n_busy, n_done, done_cyc, first_valid, last_hs, unstable;
    logic [15:0] lfsr;

    function automatic logic exp_bit(input int a);
        logic [13:0] k;
        k = 14'(a);
        return k[0] ^ k[3];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: ready high; 1: LFSR-driven ready; 3: ready high until 3 bits taken, then low
    task automatic xfer(input int addr, input int len, input int mode, input int ncyc, input int restart_at);
        logic prev_stall;
        logic prev_bit;
        bits_q.delete();
        addr_q.delete();
        n_en = 0; n_busy = 0; n_done = 0; done_cyc = -1; first_valid = -1; last_hs = -1; unstable = 0;
        prev_stall = 1'b0; prev_bit = 1'b0;
        lfsr = 16'd1;
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start      = 1'b1;
                start_addr = 14'(addr);
                length     = 15'(len);
            end else begin
                start = (c == restart_at);
            end
            case (mode)
                1: begin
                    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    data_ready = lfsr[0];
                end
                3:       data_ready = (bits_q.size() < 3);
                default: data_ready = 1'b1;
            endcase
            if (ram_en) begin n_en++; addr_q.push_back(int'(ram_addr)); end
            if (busy) n_busy++;
            if (done) begin n_done++; done_cyc = c; end
            if (data_valid && first_valid < 0) first_valid = c;
            if (prev_stall && (data_out !== prev_bit || !data_valid)) unstable++;
            if (data_valid && data_ready) begin bits_q.push_back(data_out); last_hs = c; end
            prev_stall = data_valid && !data_ready;
            prev_bit   = data_out;
            if (n_done > 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
    endtask

    function automatic int seq_errs(input int addr);
        int e = 0;
        for (int i = 0; i < bits_q.size(); i++)
            if (bits_q[i] !== exp_bit(addr + i)) e++;
        return e;
    endfunction

    initial begin
        for (int k = 0; k < 16384; k++) mem[k] = exp_bit(k);
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; data_ready = 1'b0; ram_do = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_outs",  32'({ram_en, ram_addr, data_valid, data_out}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic transfer, ready held high
        xfer(5, 8, 0, 60, -1);
        check("t1_count",   32'(bits_q.size()), 8);
        check("t1_seq",     32'(seq_errs(5)), 0);
        check("t1_first",   32'(first_valid), 2);
        check("t1_en",      32'(n_en), 8);
        check("t1_done_n",  32'(n_done), 1);
        check("t1_done_at", 32'(done_cyc), 32'(last_hs + 1));
        check("t1_busy",    32'(n_busy), 10);
        check("t1_addr0",   32'(addr_q[0]), 5);

        // Same transfer under pseudo-random backpressure
        xfer(5, 8, 1, 300, -1);
        check("t2_count",  32'(bits_q.size()), 8);
        check("t2_seq",    32'(seq_errs(5)), 0);
        check("t2_stable", 32'(unstable), 0);
        check("t2_en",     32'(n_en), 8);
        check("t2_done_n", 32'(n_done), 1);
        check("t2_done_at", 32'(done_cyc), 32'(last_hs + 1));

        // Address wrap at the top of the RAM
        xfer(16382, 4, 0, 40, -1);
        check("t3_count", 32'(addr_q.size()), 4);
        check("t3_a0", 32'(addr_q[0]), 16382);
        check("t3_a1", 32'(addr_q[1]), 16383);
        check("t3_a2", 32'(addr_q[2]), 0);
        check("t3_a3", 32'(addr_q[3]), 1);
        check("t3_seq", 32'(seq_errs(16382)), 0);
        check("t3_bits", 32'(bits_q.size()), 4);

        // Zero length: done only
        xfer(9, 0, 0, 20, -1);
        check("t4_en",      32'(n_en), 0);
        check("t4_valid",   32'(first_valid), 32'(-1));
        check("t4_done_n",  32'(n_done), 1);
        check("t4_done_at", 32'(done_cyc), 1);
        check("t4_busy",    32'(n_busy), 0);

        // START during a transfer is ignored
        xfer(100, 16, 0, 80, 4);
        check("t5_count",  32'(bits_q.size()), 16);
        check("t5_seq",    32'(seq_errs(100)), 0);
        check("t5_done_n", 32'(n_done), 1);
        check("t5_en",     32'(n_en), 16);

        // Reset mid-transfer after 3 bits, then a fresh short transfer
        xfer(20, 10, 3, 6, -1);
        check("t6_pre_bits", 32'(bits_q.size()), 3);
        check("t6_pre_done", 32'(n_done), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", 32'({busy, done, ram_en, ram_addr, data_valid, data_out}), 0);
        @(negedge clk);
        check("t6_rst_hold", 32'({busy, done, ram_en, data_valid}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_done", 32'(done), 0);
        xfer(7, 2, 0, 30, -1);
        check("t6_count",  32'(bits_q.size()), 2);
        check("t6_seq",    32'(seq_errs(7)), 0);
        check("t6_done_n", 32'(n_done), 1);

        // Full-depth transfer
        xfer(0, 16384, 0, 16500, -1);
        check("t7_count",  32'(bits_q.size()), 16384);
        check("t7_seq",    32'(seq_errs(0)), 0);
        check("t7_busy",   32'(n_busy), 16386);
        check("t7_done_n", 32'(n_done), 1);
        check("t7_en",     32'(n_en), 16384);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
